// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit: fixed-latency multiply (with MADD/MSUB
// accumulate) and a 32-step radix-2 restoring divide, abortable by flush.
module mul_div_unit #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] hilo_i,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [63:0] hilo_o,
   output logic        hilo_we,
   output logic [31:0] mul_rd_o
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MUL   = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;

   localparam logic [4:0] MUL_LAST_CNT = 5'(MUL_LAT - 1);
   localparam logic [4:0] DIV_LAST_CNT = 5'd31;

   state_e      state_q, state_d;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q, dvs_q;
   logic [63:0] hilo_in_q;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d;
   logic        done_q, done_d, we_q, we_d;
   logic [63:0] hilo_q, hilo_d;
   logic [31:0] rd_q, rd_d;

   // Request decode
   logic        op_valid, op_is_div, accept, in_signed_div;
   logic [31:0] a_mag, b_mag;

   assign op_valid      = (op <= OP_MSUBU);
   assign op_is_div     = (op == OP_DIV) || (op == OP_DIVU);
   assign accept        = start & ~flush & op_valid;
   assign in_signed_div = (op == OP_DIV);
   assign a_mag         = (in_signed_div && a[31]) ? -a : a;
   assign b_mag         = (in_signed_div && b[31]) ? -b : b;

   // Multiply path: 64-bit product of sign- or zero-extended operands
   logic        mul_signed;
   logic [63:0] a_ext, b_ext, product, mul_res;

   assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MUL) ||
                       (op_q == OP_MADD) || (op_q == OP_MSUB);
   assign a_ext      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
   assign b_ext      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
   assign product    = a_ext * b_ext;

   always_comb begin
      case (op_q)
         OP_MADD, OP_MADDU: mul_res = hilo_in_q + product;
         OP_MSUB, OP_MSUBU: mul_res = hilo_in_q - product;
         default:           mul_res = product;
      endcase
   end

   // Restoring divide step on magnitudes; rem stays below the divisor, so a
   // 33-bit difference is enough to decide whether the subtraction fits.
   logic [32:0] shifted, diff;
   logic        fits;
   logic [31:0] rem_nx, quo_nx;

   assign shifted = {rem_q, quo_q[31]};
   assign diff    = shifted - {1'b0, dvs_q};
   assign fits    = ~diff[32];
   assign rem_nx  = fits ? diff[31:0] : shifted[31:0];
   assign quo_nx  = {quo_q[30:0], fits};

   logic        div_signed, a_neg, b_neg;
   logic [31:0] quo_fix, rem_fix;
   logic [63:0] div_res;

   assign div_signed = (op_q == OP_DIV);
   assign a_neg      = div_signed & a_q[31];
   assign b_neg      = div_signed & b_q[31];
   assign quo_fix    = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
   assign rem_fix    = a_neg ? -rem_nx : rem_nx;
   assign div_res    = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};

   // NOTE: every clocked register uses <= so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // NOTE: each always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (accept) state_d = op_is_div ? S_DIV : S_MUL;
            S_MUL:   if (cnt_q == MUL_LAST_CNT) state_d = S_DONE;
            S_DIV:   if (cnt_q == DIV_LAST_CNT) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      stall  = resetn & (((state_q == S_IDLE) & start & op_valid) |
                         (state_q == S_MUL) | (state_q == S_DIV));
      done_d = 1'b0;
      we_d   = 1'b0;
      hilo_d = '0;
      rd_d   = '0;
      // DONE is only ever entered from MUL or DIV, never on a flush.
      if (state_d == S_DONE) begin
         done_d = 1'b1;
         if (state_q == S_DIV) begin
            we_d   = 1'b1;
            hilo_d = div_res;
         end else begin
            we_d   = (op_q != OP_MUL);
            hilo_d = mul_res;
            rd_d   = product[31:0];
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      rem_d = rem_q;
      quo_d = quo_q;
      case (state_q)
         S_IDLE: if (accept) begin
            cnt_d = '0;
            rem_d = '0;
            quo_d = a_mag;
         end
         S_MUL: cnt_d = cnt_q + 5'd1;
         S_DIV: begin
            cnt_d = cnt_q + 5'd1;
            rem_d = rem_nx;
            quo_d = quo_nx;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         dvs_q     <= '0;
         hilo_in_q <= '0;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         done_q    <= 1'b0;
         we_q      <= 1'b0;
         hilo_q    <= '0;
         rd_q      <= '0;
      end else begin
         if (state_q == S_IDLE && accept) begin
            op_q      <= op;
            a_q       <= a;
            b_q       <= b;
            dvs_q     <= b_mag;
            hilo_in_q <= hilo_i;
         end
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         done_q <= done_d;
         we_q   <= we_d;
         hilo_q <= hilo_d;
         rd_q   <= rd_d;
      end
   end

   assign done     = done_q;
   assign hilo_we  = we_q;
   assign hilo_o   = hilo_q;
   assign mul_rd_o = rd_q;

endmodule
